// File: rtl/ctrl_mux_pkg.sv
// Shared types for the controller source multiplexer: mode and auto-select encodings.
package ctrl_mux_pkg;

    localparam int SNES_W = 12;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_AUTO  = 2'd1,
        MODE_MERGE = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic {
        A_IDLE   = 1'b0,
        A_LOCKED = 1'b1
    } auto_state_e;

endpackage

// File: rtl/ctrl_chan_hold.sv
// One controller channel: last captured button word, no-valid timeout counter and stale flag.
module ctrl_chan_hold
    import ctrl_mux_pkg::*;
#(
    parameter int W       = SNES_W,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [W-1:0] data,
    output logic [W-1:0] hold,
    output logic         stale
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold  <= '0;
            cnt   <= '0;
            stale <= 1'b1;
        end else if (valid) begin
            hold  <= data;
            cnt   <= '0;
            stale <= 1'b0;
        end else if (cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + CW'(1);
            // Dropping the word on timeout releases buttons whose release event was lost.
            if (cnt == CW'(TIMEOUT - 1)) begin
                stale <= 1'b1;
                hold  <= '0;
            end
        end
    end

endmodule

// File: rtl/ctrl_source_mux.sv
// Selects or merges N controller channels into one button word, updated only at frame strobes.
module ctrl_source_mux
    import ctrl_mux_pkg::*;
#(
    parameter int N_CH    = 3,
    parameter int W       = SNES_W,
    parameter int TIMEOUT = 1_000_000,
    parameter int SELW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] ch_data,
    input  logic [N_CH-1:0]   ch_valid,
    input  logic [SELW-1:0]   sel,
    input  logic [1:0]        mode,
    input  logic              frame_strobe,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_src,
    output logic              out_active
);

    logic [N_CH-1:0][W-1:0] hold;
    logic [N_CH-1:0]        stale;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ctrl_chan_hold #(.W(W), .TIMEOUT(TIMEOUT)) u_hold (
            .clk   (clk),
            .rst   (rst),
            .valid (ch_valid[g]),
            .data  (ch_data[g*W +: W]),
            .hold  (hold[g]),
            .stale (stale[g])
        );
    end

    mode_e mode_c;
    assign mode_c = mode_e'(mode);

    // Lowest-numbered channel that is fresh and has something pressed.
    logic            found;
    logic [SELW-1:0] first_idx;

    always_comb begin
        found     = 1'b0;
        first_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (!stale[i] && hold[i] != '0) begin
                found     = 1'b1;
                first_idx = SELW'(i);
            end
        end
    end

    auto_state_e     state, state_nxt;
    logic [SELW-1:0] lock, lock_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= A_IDLE;
            lock  <= '0;
        end else begin
            state <= state_nxt;
            lock  <= lock_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock;
        if (mode_c != MODE_AUTO) begin
            state_nxt = A_IDLE;
        end else begin
            case (state)
                A_IDLE: if (found) begin
                    state_nxt = A_LOCKED;
                    lock_nxt  = first_idx;
                end
                A_LOCKED: if (stale[lock]) state_nxt = A_IDLE;
                default: state_nxt = A_IDLE;
            endcase
        end
    end

    logic [W-1:0]    cand;
    logic [SELW-1:0] cand_src;
    logic            cand_act;
    logic            sel_ok;

    assign sel_ok = (int'(sel) < N_CH);

    always_comb begin
        cand     = '0;
        cand_src = '0;
        cand_act = 1'b0;
        case (mode_c)
            MODE_AUTO: if (state == A_LOCKED) begin
                cand     = hold[lock];
                cand_src = lock;
                cand_act = !stale[lock];
            end
            MODE_MERGE: begin
                for (int i = 0; i < N_CH; i++)
                    if (!stale[i]) cand = cand | hold[i];
                cand_act = |(~stale);
            end
            default: begin
                // Reserved mode falls through to fixed selection; out_src reports sel even if unmapped.
                cand_src = sel;
                if (sel_ok && !stale[sel]) begin
                    cand     = hold[sel];
                    cand_act = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_src    <= '0;
            out_active <= 1'b0;
        end else if (frame_strobe) begin
            out_data   <= cand;
            out_src    <= cand_src;
            out_active <= cand_act;
        end
    end

endmodule

// File: tb/tb_ctrl_source_mux.sv
// Directed bench for ctrl_source_mux with a per-cycle reference model of channel age and selection.
module tb_ctrl_source_mux;

    localparam int N  = 3;
    localparam int W  = 12;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*W-1:0]  ch_data;
    logic [N-1:0]    ch_valid;
    logic [1:0]      sel;
    logic [1:0]      mode;
    logic            frame_strobe;
    logic [W-1:0]    out_data;
    logic [1:0]      out_src;
    logic            out_active;

    ctrl_source_mux #(.N_CH(N), .W(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_data      (ch_data),
        .ch_valid     (ch_valid),
        .sel          (sel),
        .mode         (mode),
        .frame_strobe (frame_strobe),
        .out_data     (out_data),
        .out_src      (out_src),
        .out_active   (out_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic done = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a channel is fresh if it was captured fewer than TO edges ago.
    logic [W-1:0] mdat [N];
    logic         seen [N];
    int           last [N];
    int           e     = 0;
    int           mlock = -1;
    logic [W-1:0] exp_data = '0;
    logic [1:0]   exp_src  = '0;
    logic         exp_act  = 1'b0;

    function automatic logic st(input int i);
        return !seen[i] || (e - last[i] >= TO);
    endfunction

    function automatic logic [W-1:0] hv(input int i);
        return st(i) ? '0 : mdat[i];
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin seen[i] = 1'b0; last[i] = 0; mdat[i] = '0; end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                e = 0; mlock = -1;
                for (int i = 0; i < N; i++) seen[i] = 1'b0;
                exp_data = '0; exp_src = '0; exp_act = 1'b0;
            end else begin
                if (frame_strobe) begin
                    exp_data = '0; exp_src = '0; exp_act = 1'b0;
                    if (mode == 2'd2) begin
                        for (int i = 0; i < N; i++)
                            if (!st(i)) begin exp_data |= hv(i); exp_act = 1'b1; end
                    end else if (mode == 2'd1) begin
                        if (mlock >= 0) begin
                            exp_data = hv(mlock); exp_src = 2'(mlock); exp_act = !st(mlock);
                        end
                    end else begin
                        exp_src = sel;
                        if (int'(sel) < N && !st(int'(sel))) begin
                            exp_data = hv(int'(sel)); exp_act = 1'b1;
                        end
                    end
                end
                if (mode != 2'd1) mlock = -1;
                else if (mlock < 0) begin
                    for (int i = 0; i < N; i++)
                        if (mlock < 0 && !st(i) && hv(i) != '0) mlock = i;
                end else if (st(mlock)) mlock = -1;
                e++;
                for (int i = 0; i < N; i++)
                    if (ch_valid[i]) begin seen[i] = 1'b1; last[i] = e; mdat[i] = ch_data[i*W +: W]; end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                chk("cyc out_data",   int'(out_data),   int'(exp_data));
                chk("cyc out_src",    int'(out_src),    int'(exp_src));
                chk("cyc out_active", int'(out_active), int'(exp_act));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int ch, input logic [W-1:0] d);
        ch_data[ch*W +: W] = d;
        ch_valid[ch] = 1'b1;
        @(negedge clk);
        ch_valid[ch] = 1'b0;
    endtask

    task automatic strobe();
        frame_strobe = 1'b1;
        @(negedge clk);
        frame_strobe = 1'b0;
    endtask

    initial begin
        ch_data = '0; ch_valid = '0; sel = '0; mode = '0; frame_strobe = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("reset out_data", int'(out_data), 0);
        chk("reset out_src", int'(out_src), 0);
        chk("reset out_active", int'(out_active), 0);

        sel = 2'd1;
        pulse(1, 12'h0A5);
        strobe();
        chk("fixed out_data", int'(out_data), 'h0A5);
        chk("fixed out_src", int'(out_src), 1);
        chk("fixed out_active", int'(out_active), 1);
        pulse(1, 12'h03C);
        tick(3);
        chk("no_strobe hold", int'(out_data), 'h0A5);

        sel = 2'd0;
        pulse(0, 12'hFFF);
        tick(99);
        strobe();
        chk("edge99 out_data", int'(out_data), 'hFFF);
        strobe();
        chk("timeout out_data", int'(out_data), 0);
        chk("timeout out_active", int'(out_active), 0);
        pulse(0, 12'hFFF);
        tick(99);
        pulse(0, 12'hFFF);
        tick(5);
        strobe();
        chk("valid_at_100 out_data", int'(out_data), 'hFFF);
        chk("valid_at_100 out_active", int'(out_active), 1);

        mode = 2'd1;
        tick(110);
        pulse(2, 12'h010);
        tick(2);
        pulse(0, 12'h001);
        strobe();
        chk("auto lock2 out_data", int'(out_data), 'h010);
        chk("auto lock2 out_src", int'(out_src), 2);
        ch_data[0 +: W] = 12'h001;
        ch_valid[0] = 1'b1;
        tick(105);
        strobe();
        chk("auto relock out_data", int'(out_data), 'h001);
        chk("auto relock out_src", int'(out_src), 0);
        chk("auto relock out_active", int'(out_active), 1);
        ch_valid[0] = 1'b0;

        pulse(1, 12'h100);
        mode = 2'd2;
        strobe();
        chk("merge out_data", int'(out_data), 'h101);
        chk("merge out_src", int'(out_src), 0);

        mode = 2'd0; sel = 2'd3;
        strobe();
        chk("oor out_data", int'(out_data), 0);
        chk("oor out_src", int'(out_src), 3);
        chk("oor out_active", int'(out_active), 0);
        mode = 2'd3; sel = 2'd1;
        strobe();
        chk("rsvd out_data", int'(out_data), 'h100);
        chk("rsvd out_src", int'(out_src), 1);
        sel = 2'd3;
        strobe();
        chk("rsvd oor out_src", int'(out_src), 3);

        mode = 2'd0; sel = 2'd1;
        frame_strobe = 1'b1;
        pulse(1, 12'h055);
        tick(2);
        frame_strobe = 1'b0;
        chk("held strobe out_data", int'(out_data), 'h055);

        pulse(1, 12'h0A5);
        strobe();
        chk("pre_rst out_data", int'(out_data), 'h0A5);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_data", int'(out_data), 0);
        chk("async rst out_active", int'(out_active), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        strobe();
        chk("post_rst out_data", int'(out_data), 0);
        chk("post_rst out_active", int'(out_active), 0);

        done = 1'b1;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_source_mux.md
Name: ctrl_source_mux

Overview:
- Parametrised, registered successor to the fixed three-source controller multiplexer.
- Selects or merges N controller-input channels into one W-bit button word for the SNES serializer. Typical channels: PS/2 keyboard decode, IR decode, push-buttons.
- Adds per-channel hold with stale timeout, auto-select and merge modes, and frame-synchronous output update so the console never sees a mid-frame source switch.

Parameters:
- N_CH, 3, number of input channels (>=2).
- W, 12, button-word width (SNES: B,Y,Sel,Start,Up,Dn,L,R,A,X,L,R).
- TIMEOUT, 1_000_000, clk cycles without ch_valid before a channel is stale.
- SELW, $clog2(N_CH), select width (derived; minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ch_data  in  N_CH*W  packed channel words, channel i at [i*W +: W], 1 = pressed.
- ch_valid  in  N_CH  per-channel capture strobe; may be held high continuously (buttons).
- sel  in  SELW  fixed-mode channel select (from dip).
- mode  in  2  0 FIXED, 1 AUTO, 2 MERGE, 3 reserved (treated as FIXED).
- frame_strobe  in  1  one-cycle pulse at SNES latch; output update point.
- out_data  out  W  button word to serializer.
- out_src  out  SELW  channel driving out_data (0 in MERGE).
- out_active  out  1  out_data comes from at least one non-stale channel.

Behaviour:
- Reset (async assert, sync release): all hold regs, timeout counters, out_data, out_src and out_active are 0. Every channel is stale. Auto FSM is IDLE.
- Per channel i:
  - ch_valid[i]=1: hold_i <= ch_data slice, cnt_i <= 0, stale_i <= 0.
  - Otherwise cnt_i increments and saturates at TIMEOUT. On reaching TIMEOUT: stale_i <= 1 and hold_i <= 0, which clears stuck buttons from a lost IR or PS/2 release.
  - If ch_valid and saturation occur in the same cycle, valid wins.
- Candidate word, combinational, from holds:
  - FIXED: hold[sel] if sel < N_CH and not stale; else 0.
  - AUTO: hold[lock] when LOCKED; 0 when IDLE.
  - MERGE: bitwise OR of all non-stale holds.
- Auto FSM (advances every clk, independent of frame_strobe):
  - IDLE -> LOCKED(lock = lowest i with !stale_i and hold_i != 0).
  - LOCKED -> IDLE when stale_lock.
  - Other channels are ignored while LOCKED.
  - A mode change away from AUTO forces IDLE next cycle.
- Output registers load only in the cycle after frame_strobe=1 (1-cycle latency) and hold otherwise:
  - out_data <= candidate.
  - out_src <= sel (FIXED, even when out of range), lock (AUTO LOCKED), 0 otherwise.
  - out_active <= (candidate source non-stale).
- frame_strobe held high for k cycles updates on every one of those cycles; no edge detection.
- Changes to sel or mode between strobes have no effect on outputs until the next strobe.
- Reset mid-frame clears outputs immediately. The first post-reset strobe outputs 0 unless valid has arrived.

Decomposition:
- ctrl_mux_pkg holds:
  - mode_e enum (MODE_FIXED, MODE_AUTO, MODE_MERGE, MODE_RSVD);
  - auto_state_e (A_IDLE, A_LOCKED);
  - a default SNES_W = 12 constant.
- Sub-module ctrl_chan_hold (W, TIMEOUT) holds the register, timeout counter and stale flag. It is instantiated N_CH times via generate.
- Mode mux, FSM and output regs live in the top.

Test Plan:
- N_CH=3, W=12, TIMEOUT=100. FIXED, sel=1, ch1 valid with 12'h0A5, then strobe -> out_data=12'h0A5, out_src=1, out_active=1 one cycle after strobe. The value is unchanged if ch1 data changes without a strobe.
- Timeout: ch0 valid once with 12'hFFF, then no valid for 100 clk, FIXED sel=0, strobe -> out_data=0, out_active=0. A valid at exactly cycle 100 instead keeps 12'hFFF.
- AUTO: ch2=12'h010 then ch0=12'h001, strobe -> lock=2, out_data=12'h010. Let ch2 go stale while ch0 stays fresh, strobe -> out_data=12'h001, out_src=0.
- MERGE: ch0=12'h001, ch1=12'h100, ch2 stale, strobe -> out_data=12'h101, out_src=0.
- Out of range and reserved: sel=3 with N_CH=3 -> out_data=0, out_src=3. mode=3 behaves identically to FIXED.
- Async rst asserted mid-frame with out_data=12'h0A5 -> outputs 0 in the same cycle. After release, strobe with no valid -> out_data=0.
